// File: rtl/counter_sched.sv
// Round-robin scheduler that lends one external counter to two requesters,
// clearing it, running it up to the granted requester's target, then pulsing done.
module counter_sched #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic             err,
  output logic             busy,
  output logic             cnt_clr,
  output logic             cnt_en,
  input  logic [CNT_W-1:0] cnt_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [1:0]       grant_n;
  logic [CNT_W-1:0] target, target_n;
  logic             last, last_n;
  logic             err_n;
  logic             win;

  // Pointer holds the last-served requester; on a tie the other one wins.
  always_comb begin
    win = ~last;
    if (req == 2'b01)      win = 1'b0;
    else if (req == 2'b10) win = 1'b1;
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    target_n = target;
    last_n   = last;
    err_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req != 2'b00) begin
          grant_n  = win ? 2'b10 : 2'b01;
          target_n = win ? len1 : len0;
          last_n   = win;
          state_n  = CLEAR;
        end
      end
      CLEAR: state_n = RUN;
      RUN: begin
        // Reaching the target ends the interval; passing it is flagged as an error.
        if (cnt_count >= target) begin
          state_n = DONE;
          err_n   = (cnt_count > target);
        end
      end
      DONE: begin
        grant_n = 2'b00;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      grant  <= 2'b00;
      target <= '0;
      last   <= 1'b1;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      target <= target_n;
      last   <= last_n;
      err    <= err_n;
    end
  end

  assign busy    = (state != IDLE);
  assign cnt_clr = (state == CLEAR);
  assign done    = (state == DONE) ? grant : 2'b00;
  // Stopping the enable at the target keeps the counter from ever wrapping.
  assign cnt_en  = (state == RUN) && (cnt_count != target);

endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that shares one `counter` instance between two requesters. Each requester asks for a count interval of a given length. The scheduler grants one requester at a time. For the granted requester it clears the counter, enables it until the count reaches the requested target, and then pulses `done` back to that requester. It sits between the requesting logic and the counter's `reset`/`enable`/`count` pins; the counter itself is unchanged.

## Interface
- `CNT_W`, 4, width of the shared counter and of the length fields.
- `clk`  in  1  system clock, all state updates on posedge.
- `reset`  in  1  asynchronous, active-low; asserted (0) forces every register to its reset value immediately.
- `req`  in  2  level request, bit i = requester i.
- `len0`  in  CNT_W  target count for requester 0; sampled only at grant.
- `len1`  in  CNT_W  target count for requester 1; sampled only at grant.
- `grant`  out  2  one-hot (or zero) owner of the counter.
- `done`  out  2  one-cycle pulse to the owner at the end of its interval.
- `err`  out  1  one-cycle pulse, coincident with `done`, when an overshoot is detected.
- `busy`  out  1  high in every state except IDLE.
- `cnt_clr`  out  1  drives the counter's synchronous `reset`.
- `cnt_en`  out  1  drives the counter's `enable`.
- `cnt_count`  in  CNT_W  counter's `count` output.

## Operation
- States: IDLE, CLEAR, RUN, DONE; 2-bit encoded; reset value IDLE.
- Reset values:
  - `grant`=0, `done`=0, `err`=0, `busy`=0, `cnt_clr`=0, `cnt_en`=0.
  - Target register = 0.
  - Last-served pointer = 1, so requester 0 wins the first tie.
- IDLE:
  - If `req`≠0, pick the winner, latch its `len` into the target register, set `grant` to the winner, and go to CLEAR.
  - Otherwise stay in IDLE.
- Arbitration:
  - A single request wins outright.
  - If both bits are set, the requester not equal to the last-served pointer wins.
  - The pointer updates to the winner at grant.
- CLEAR: `cnt_clr`=1 for exactly one cycle, then go to RUN.
- RUN:
  - `cnt_en` = (`cnt_count` != target), decoded combinationally from state and compare. The counter therefore never passes the target and never wraps.
  - Leave for DONE in the cycle where `cnt_count` == target.
  - Also leave for DONE if `cnt_count` > target (overshoot); in that case `err` is set in the DONE cycle.
- DONE:
  - `done[owner]`=1 and `grant` held for this one cycle.
  - Next state IDLE; `grant` clears on entry to IDLE.
- `req` changes after grant are ignored until IDLE.
- A requester still asserting `req` in IDLE re-arbitrates normally, at lower priority than the other requester.
- Target = 0 is legal: RUN lasts one cycle with `cnt_en`=0, then DONE.
- Asserting `reset` mid-operation aborts the interval:
  - No `done` is issued.
  - The counter value is left as is; the next grant clears it.

## Timing
- E0 is the posedge where IDLE samples `req`≠0.
- After E0: state CLEAR, `grant` valid, `cnt_clr`=1.
- At E1: counter loads 0; state RUN.
- At E(1+k): `cnt_count`=k for k ≤ len.
- `cnt_en` is high in RUN for exactly len cycles.
- At E(2+len): state DONE and `done` high for one cycle.
- At E(3+len): state IDLE, `grant`=0.
- The earliest next grant is sampled at E(4+len).
- Total occupancy is len+3 cycles from grant to IDLE.
- `busy` is high from E0 through E(3+len).
- `cnt_clr`, `grant`, `done`, `err` and `busy` are registered or pure state decodes; only `cnt_en` depends combinationally on `cnt_count`.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles, then release. Required: all outputs 0 and state IDLE. With `req`=00, outputs stay 0 for 10 cycles.
- **Single request:** `req`=01, `len0`=5. Required:
  - `grant`=01 one cycle after sampling.
  - `cnt_clr` pulses once; `cnt_en` high for 5 cycles; `cnt_count` ends at 5.
  - `done`=01 for one cycle, 7 cycles after the sampling edge.
  - Self-check model counts match every cycle.
- **Contention:** `req`=11 held, `len0`=3, `len1`=2. Required:
  - Grants alternate 01, 10, 01, …
  - Each `done` goes to the matching bit.
  - Gaps between intervals are exactly 1 IDLE cycle.
- **Boundaries:**
  - `len1`=0: `cnt_en` never high; `done`=10 two cycles after CLEAR.
  - `len0`=15: `cnt_count` reaches 15; no wrap to 0; `done`=01.
- **Reset mid-RUN:** assert `reset` when `cnt_count`=2 of `len0`=6. Required:
  - Outputs go to 0 immediately; no `done`.
  - After release, a new `req`=01 starts from CLEAR and completes normally.
- **Overshoot:** force `cnt_count`=9 during RUN with target 4. Required: next cycle `done`=01 and `err`=1 for one cycle, then IDLE.
